led_frame_sequencer: RTL
========================

// Module: led_frame_sequencer
// PURPOSE
//   Frame scheduler for the ledcontroller pixel pipeline. Steps ledindex through
//   0..NUM_LEDS-1 and holds each index until the free-running pipeline has settled.
//   Captures red/green/blue, packs them GRB and hands each pixel to the WS2811
//   serializer over valid/ready. After the last pixel it enforces the WS2811
//   latch gap, then reports frame completion.
// PARAMETERS
//   NUM_LEDS       64    pixels per frame, 1..256
//   SETTLE_CYCLES  24    clocks ledindex is held before rgb sampling (3 pipeline wraps), >=1
//   LATCH_CYCLES   2500  idle clocks after the last pixel (50 us at 50 MHz), >=1
// PORTS
//   clk          in   1   system clock, the only clock
//   rst_n        in   1   synchronous active-low reset
//   enable       in   1   when low, no new frame is started
//   frame_req    in   1   1-cycle pulse requesting one frame
//   red          in   8   ledcontroller output
//   green        in   8   ledcontroller output
//   blue         in   8   ledcontroller output
//   ledindex     out  8   index driven to ledcontroller
//   pixel_data   out  24  {green,red,blue} to serializer
//   pixel_valid  out  1   pixel_data valid
//   pixel_ready  in   1   serializer accepts pixel
//   frame_busy   out  1   high from frame start until frame_done
//   frame_done   out  1   1-cycle pulse at end of latch gap
// BEHAVIOUR
//   Reset (rst_n low at posedge): state IDLE; ledindex=0, pixel_data=0, pixel_valid=0,
//     frame_busy=0, frame_done=0, pending=0, counters=0. Reset mid-frame drops valid at once.
//   States: IDLE -> SETTLE -> OFFER -> (SETTLE | LATCH) -> IDLE.
//   IDLE: starts a frame when (frame_req|pending)&enable: ledindex<=0, frame_busy<=1,
//     pending<=0, go to SETTLE. A start with enable=0 leaves pending set.
//   SETTLE: count SETTLE_CYCLES clocks. Capture happens on the edge SETTLE_CYCLES clocks after
//     the edge that updated ledindex: pixel_data<={green,red,blue}, pixel_valid<=1, go to OFFER.
//   OFFER: transfer = pixel_valid&pixel_ready at posedge. Until transfer, pixel_data and
//     ledindex hold and pixel_valid stays 1 (no retraction). On the transfer edge
//     pixel_valid<=0. If ledindex<NUM_LEDS-1, ledindex<=ledindex+1 and go to SETTLE;
//     otherwise go to LATCH. ready high before valid -> transfer on first valid cycle.
//     Min pixel period = SETTLE_CYCLES+1 clocks.
//   LATCH: count LATCH_CYCLES clocks with pixel_valid=0. On the final count: frame_done<=1
//     for one cycle, frame_busy<=0, ledindex<=0, go to IDLE.
//     A new frame starts at earliest the cycle after frame_done.
//   frame_req while frame_busy: sets pending (one-deep; extra requests coalesce).
//     frame_req on the frame_done cycle also sets pending.
//   enable low mid-frame: current frame completes normally. Only IDLE starts are gated.
//   NUM_LEDS=1: a single SETTLE/OFFER, then LATCH. Index never wraps past NUM_LEDS-1.
//   Counters are sized $clog2(max(param,2))+1 bits; no arithmetic overflow is permitted.
// STRUCTURE
//   Shared package: state encoding constants (IDLE/SETTLE/OFFER/LATCH) and the WS2811
//     timing constants (default latch count, GRB packing order), for reuse by the serializer.
//   One sub-module: led_gap_counter (load/count-down/zero flag), used for both SETTLE and
//     LATCH timing. The FSM stays in this module.
// TESTING (NUM_LEDS=4, SETTLE_CYCLES=24, LATCH_CYCLES=10 unless stated)
//   Basic frame, ready tied 1: ledindex 0,1,2,3. 4 transfers, each 24 clks after the index
//     edge, period 25. frame_done 10 clks after the last transfer. busy high throughout.
//   Backpressure: ready=0 for 7 clks at pixel 2 -> valid held 8 clks,
//     pixel_data/ledindex constant, then ledindex=3.
//   Data capture: drive red=11,green=22,blue=33 at index 1 -> pixel_data=0x16_0B_21.
//   Request while busy, 3 pulses during frame -> exactly one extra frame, which starts
//     the cycle after frame_done.
//   enable=0 + frame_req in IDLE -> no activity. Raise enable 50 clks later -> frame starts next cycle.
//   rst_n low during OFFER -> next cycle valid=0, busy=0, ledindex=0. No frame_done.
//     After release, IDLE awaits a new frame_req.

Source files
------------

// File: rtl/led_frame_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_frame_sequencer_pkg: FSM state encoding and WS2811 frame timing shared
// between the frame sequencer and the serializer. Rev 1.0
// ----------------------------------------------------------------------------
package led_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OFFER  = 2'd2,
    ST_LATCH  = 2'd3
  } seq_state_e;

  // Three wraps of the ledcontroller pipeline; 50 us reset gap at 50 MHz.
  localparam int PIPE_SETTLE_CYCLES  = 24;
  localparam int WS2811_LATCH_CYCLES = 2500;

  // WS2811 shifts green first, then red, then blue.
  localparam int GRB_G_LSB = 16;
  localparam int GRB_R_LSB = 8;
  localparam int GRB_B_LSB = 0;

  function automatic logic [23:0] pack_grb(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    logic [23:0] word;
    word = '0;
    word[GRB_G_LSB +: 8] = g;
    word[GRB_R_LSB +: 8] = r;
    word[GRB_B_LSB +: 8] = b;
    return word;
  endfunction

  function automatic int gap_cnt_width(input int cycles);
    return $clog2((cycles < 2) ? 2 : cycles) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_frame_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_frame_sequencer_if: packed-pixel valid/ready stream to the WS2811
// serializer. Rev 1.0
// ----------------------------------------------------------------------------
interface led_frame_sequencer_if;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (output pixel_data, output pixel_valid, input pixel_ready);
  modport slave  (input pixel_data, input pixel_valid, output pixel_ready);
endinterface
`default_nettype wire

// File: rtl/led_gap_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_gap_counter: loadable down-counter with zero flag, used for the pixel
// settle time and the latch gap. Rev 1.0
// ----------------------------------------------------------------------------
module led_gap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Saturates at zero so a late dec never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/led_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_frame_sequencer: walks ledindex over the strip, samples settled RGB,
// offers GRB pixels to the serializer and enforces the WS2811 latch gap. Rev 1.0
// ----------------------------------------------------------------------------
module led_frame_sequencer
  import led_frame_sequencer_pkg::*;
#(
  parameter int NUM_LEDS      = 64,
  parameter int SETTLE_CYCLES = PIPE_SETTLE_CYCLES,
  parameter int LATCH_CYCLES  = WS2811_LATCH_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          frame_req,
  input  logic [7:0]                    red,
  input  logic [7:0]                    green,
  input  logic [7:0]                    blue,
  output logic [7:0]                    ledindex,
  output logic                          frame_busy,
  output logic                          frame_done,
  led_frame_sequencer_if.master         pix
);

  localparam int CNT_MAX = (SETTLE_CYCLES > LATCH_CYCLES) ? SETTLE_CYCLES : LATCH_CYCLES;
  localparam int CNT_W   = gap_cnt_width(CNT_MAX);

  // Loading N-1 makes the zero flag line up with the Nth edge after the load.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_LOAD  = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [7:0]       LAST_IDX    = 8'(NUM_LEDS - 1);

  seq_state_e  state_q;
  logic [7:0]  ledindex_q;
  logic [23:0] pixel_data_q;
  logic        pixel_valid_q;
  logic        frame_busy_q;
  logic        frame_done_q;
  logic        pending_q;
  logic        pending_d;

  logic             start;
  logic             transfer;
  logic             last_pixel;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_value;
  logic             cnt_zero;

  assign start      = (state_q == ST_IDLE) && (frame_req || pending_q) && enable;
  assign transfer   = pixel_valid_q && pix.pixel_ready;
  assign last_pixel = (ledindex_q == LAST_IDX);

  // One-deep request memory: anything not consumed by an IDLE start coalesces here.
  always_comb begin
    pending_d = pending_q || frame_req;
    if (start) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cnt_load_value = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_load       = 1'b1;
          cnt_load_value = SETTLE_LOAD;
        end
      end
      ST_SETTLE: cnt_dec = 1'b1;
      ST_OFFER: begin
        if (transfer) begin
          cnt_load       = 1'b1;
          cnt_load_value = last_pixel ? LATCH_LOAD : SETTLE_LOAD;
        end
      end
      ST_LATCH: cnt_dec = 1'b1;
      default: cnt_dec = 1'b0;
    endcase
  end

  led_gap_counter #(
    .WIDTH (CNT_W)
  ) u_gap_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (cnt_load),
    .load_value_i (cnt_load_value),
    .dec_i        (cnt_dec),
    .zero_o       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ledindex_q    <= 8'd0;
      pixel_data_q  <= 24'd0;
      pixel_valid_q <= 1'b0;
      frame_busy_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      pending_q    <= pending_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            ledindex_q   <= 8'd0;
            frame_busy_q <= 1'b1;
            state_q      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            pixel_data_q  <= pack_grb(red, green, blue);
            pixel_valid_q <= 1'b1;
            state_q       <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          // Valid is never retracted; data and index hold until accepted.
          if (transfer) begin
            pixel_valid_q <= 1'b0;
            if (last_pixel) begin
              state_q <= ST_LATCH;
            end else begin
              ledindex_q <= ledindex_q + 8'd1;
              state_q    <= ST_SETTLE;
            end
          end
        end
        ST_LATCH: begin
          if (cnt_zero) begin
            frame_done_q <= 1'b1;
            frame_busy_q <= 1'b0;
            ledindex_q   <= 8'd0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ledindex        = ledindex_q;
  assign frame_busy      = frame_busy_q;
  assign frame_done      = frame_done_q;
  assign pix.pixel_data  = pixel_data_q;
  assign pix.pixel_valid = pixel_valid_q;

endmodule
`default_nettype wire
